// File: rtl/core_fetch_pkg.sv
// Shared types for the instruction-fetch stage: decode-facing register bundle,
// fetch FSM states and next-PC source encoding.
package core_fetch_pkg;

    typedef struct packed {
        logic [63:0] fetch_pc;
        logic [63:0] fetch_pc4;
    } IF_regs_t;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_BR,
        PC_ERET,
        PC_EXC
    } pc_src_t;

    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC redirect selector: resolves exception > ERET > branch priority and
// returns the winning source plus its word-aligned target.
module fetch_pc_sel
    import core_fetch_pkg::*;
#(
    parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_8000_0180
) (
    input  logic        exc_redirect,
    input  logic        eret_redirect,
    input  logic [63:0] eret_target,
    input  logic        br_redirect,
    input  logic [63:0] br_target,
    output pc_src_t     pc_src,
    output logic [63:0] redirect_pc
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_src      = PC_SEQ;
        redirect_pc = '0;
        if (exc_redirect) begin
            pc_src      = PC_EXC;
            redirect_pc = word_align(EXC_VECTOR);
        end else if (eret_redirect) begin
            pc_src      = PC_ERET;
            redirect_pc = word_align(eret_target);
        end else if (br_redirect) begin
            pc_src      = PC_BR;
            redirect_pc = word_align(br_target);
        end
    end

endmodule

// File: rtl/core_fetch.sv
// Instruction-fetch stage: owns the PC, issues valid/ready requests to imem and
// presents instructions (or NOP bubbles) to decode, parking one response under stall.
module core_fetch
    import core_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0040_0000,
    parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_8000_0180
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        exc_redirect,
    input  logic        eret_redirect,
    input  logic [63:0] eret_target,
    input  logic        br_redirect,
    input  logic [63:0] br_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output IF_regs_t    IF_regs,
    output logic [31:0] inst,
    output logic        inst_valid
);

    fetch_state_t state, state_nxt;
    pc_src_t      pc_src;
    logic [63:0]  pc, req_addr, seq_pc, redirect_pc, next_pc;
    logic         fire, accept, deliver, redirect;
    IF_regs_t     resp_regs;

    logic         hold_valid;
    IF_regs_t     hold_regs;
    logic [31:0]  hold_inst;

    fetch_pc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_pc_sel (
        .exc_redirect  (exc_redirect),
        .eret_redirect (eret_redirect),
        .eret_target   (eret_target),
        .br_redirect   (br_redirect),
        .br_target     (br_target),
        .pc_src        (pc_src),
        .redirect_pc   (redirect_pc)
    );

    assign redirect = (pc_src != PC_SEQ);
    assign next_pc  = redirect ? redirect_pc : seq_pc;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = req_addr;
        fire      = 1'b0;
        seq_pc    = pc;
        unique case (state)
            FETCH: begin
                fire      = !stall && !hold_valid;
                imem_req  = fire;
                imem_addr = pc;
                if (fire) begin
                    if (imem_ready) seq_pc    = pc + 64'd4;
                    else            state_nxt = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    seq_pc    = req_addr + 64'd4;
                    state_nxt = FETCH;
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Wrong-path request must still complete before a new one may start.
                imem_req = 1'b1;
                if (imem_ready) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
        // Gating with reset makes the request drop the instant reset asserts.
        imem_req = imem_req && reset;
        accept   = imem_req && imem_ready;
        deliver  = accept && !redirect && (state != DRAIN);
    end

    assign resp_regs = '{fetch_pc: imem_addr, fetch_pc4: imem_addr + 64'd4};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            hold_valid <= 1'b0;
            IF_regs    <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            pc    <= next_pc;
            if (fire) req_addr <= pc;

            if (flush || redirect)    hold_valid <= 1'b0;
            else if (stall && deliver) hold_valid <= 1'b1;
            else if (!stall)          hold_valid <= 1'b0;

            if (flush) begin
                IF_regs    <= '0;
                inst       <= '0;
                inst_valid <= 1'b0;
            end else if (!stall) begin
                if (hold_valid && !redirect) begin
                    IF_regs    <= hold_regs;
                    inst       <= hold_inst;
                    inst_valid <= 1'b1;
                end else if (deliver) begin
                    IF_regs    <= resp_regs;
                    inst       <= imem_rdata;
                    inst_valid <= 1'b1;
                end else begin
                    inst       <= '0;
                    inst_valid <= 1'b0;
                end
            end
        end
    end

    // NOTE: payload is only read while hold_valid is set, so it needs no reset.
    always_ff @(posedge clock) begin
        if (stall && deliver) begin
            hold_regs <= resp_regs;
            hold_inst <= imem_rdata;
        end
    end

endmodule
